mem_writer: RTL and testbench
=============================

MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of memory words; the address width is log2(DEPTH) = 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a fill pass.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data holds a word.
REQ-007 SHALL have port in_data, input, WIDTH bits: word to store.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-009 SHALL have port rd_addr, input, 8 bits: read-back address.
REQ-010 SHALL have port rd_data, output, WIDTH bits: registered read-back data.
REQ-011 SHALL have port wr_count, output, 9 bits: number of words written in the current pass, range 0..256.
REQ-012 SHALL have port done, output, 1 bit: high while a completed pass is held.

Function
REQ-013 SHALL implement the states IDLE, CLEAR, WRITE and DONE; CLEAR exists only when the MEM_WRITER_CLEAR_EN macro is defined.
REQ-014 In IDLE or DONE, start SHALL set the internal write address wr_addr to 0 and wr_count to 0, then go to CLEAR if it is compiled in, otherwise to WRITE.
REQ-015 While in CLEAR or WRITE, start SHALL be ignored.
REQ-016 in_ready SHALL be 1 exactly when the state is WRITE, decoded from the registered state with no combinational path from in_valid.
REQ-017 On each cycle with in_valid=1 and in_ready=1, the block SHALL write mem[wr_addr] = in_data, increment wr_addr (8 bits, wrapping), and increment wr_count.
REQ-018 The transfer that writes address DEPTH-1 SHALL move the state to DONE on the next edge, leaving wr_addr = 0 and wr_count = 256.
REQ-019 done SHALL be 1 exactly when the state is DONE; in DONE, in_ready = 0 and any in_valid is ignored.
REQ-020 rd_data SHALL equal mem[rd_addr] sampled at the previous edge, giving 1-cycle latency.
REQ-021 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-022 Read-back SHALL be available in every state.
REQ-023 A write address beyond DEPTH-1 is unreachable by construction, so no bounds check is needed.

Reset
REQ-024 When rst=1 at an edge: state -> IDLE; wr_addr, wr_count, done, in_ready and rd_data -> 0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 Reset in the middle of a pass SHALL abort it; words already written remain in memory.
REQ-027 rst SHALL take priority over start and over any in_valid transfer in the same cycle.

Configuration
REQ-028 With MEM_WRITER_CLEAR_EN defined, a start SHALL enter CLEAR, which writes 0 to addresses 0..DEPTH-1, one per cycle over 256 cycles, then enters WRITE with wr_addr = 0.
REQ-029 During CLEAR, in_ready = 0 and wr_count stays at 0.
REQ-030 Without MEM_WRITER_CLEAR_EN, the CLEAR state and its logic SHALL be absent, start goes directly to WRITE, and words not written keep their previous contents.

Structure
REQ-031 A package mem_writer_pkg SHALL hold the state enum type, the constants WIDTH_DEF = 4 and DEPTH_DEF = 256, and the address width constant.
REQ-032 The storage SHALL be a separate sub-module mem_writer_ram: one synchronous write port and one registered read port, DEPTH x WIDTH, no reset.
REQ-033 The FSM, the counters and the handshake SHALL be in mem_writer itself.

Verification
REQ-034 Reset, then start, then push 256 words where word i = i mod 16 with in_valid held high -> in_ready is high for exactly 256 cycles; done = 1 and wr_count = 256 afterwards; reading rd_addr = i returns i mod 16 one cycle later, for all 256 addresses.
REQ-035 Toggle in_valid on alternate cycles -> only the cycles with in_valid=1 and in_ready=1 write; the pass still ends at exactly 256 words.
REQ-036 Assert start during WRITE at wr_count = 10 -> no effect; wr_count continues to 11.
REQ-037 Assert rst at wr_count = 100 -> the next cycle shows state IDLE, wr_count = 0, in_ready = 0; addresses 0..99 keep their data.
REQ-038 In the same cycle, write 0xA to address 5 and read address 5 -> the old value is returned; a read of address 5 on the next cycle returns 0xA.
REQ-039 With MEM_WRITER_CLEAR_EN defined, a second start after a full pass -> in_ready stays 0 for 256 cycles, after which every address reads 0.

Source files
------------

// File: rtl/mem_writer_pkg.sv
// Shared types and constants for the mem_writer fill engine.
// The CLEAR state is only part of the enum when MEM_WRITER_CLEAR_EN is defined.
package mem_writer_pkg;

   localparam int unsigned WIDTH_DEF  = 4;
   localparam int unsigned DEPTH_DEF  = 256;
   localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);
   localparam int unsigned CNT_W_DEF  = ADDR_W_DEF + 1;

`ifdef MEM_WRITER_CLEAR_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;
`endif

endpackage : mem_writer_pkg

// File: rtl/mem_writer_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module mem_writer_ram #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Storage array is never reset; contents survive aborted passes.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Only the read register clears, so rd_data reads 0 straight out of reset.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : mem_writer_ram

// File: rtl/mem_writer.sv
// Fill engine: on start, accepts DEPTH words through a valid/ready port into RAM.
// Define MEM_WRITER_CLEAR_EN to zero the whole RAM before each pass.
module mem_writer
   import mem_writer_pkg::*;
#(
   parameter int unsigned  WIDTH  = WIDTH_DEF,
   parameter int unsigned  DEPTH  = DEPTH_DEF,
   localparam int unsigned ADDR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic [CNT_W-1:0]  wr_count,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e             state_q,    state_d;
   logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
   logic [CNT_W-1:0]   wr_count_q, wr_count_d;
   logic               in_ready_q;
   logic               done_q;

   logic               ram_we_c;
   logic [WIDTH-1:0]   ram_wdata_c;

   // Next-state, address/count update and RAM write strobe.
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      wr_count_d  = wr_count_q;
      ram_we_c    = 1'b0;
      ram_wdata_c = in_data;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               wr_addr_d  = '0;
               wr_count_d = '0;
`ifdef MEM_WRITER_CLEAR_EN
               state_d    = ST_CLEAR;
`else
               state_d    = ST_WRITE;
`endif
            end
         end
`ifdef MEM_WRITER_CLEAR_EN
         ST_CLEAR: begin
            ram_we_c    = 1'b1;
            ram_wdata_c = '0;
            wr_addr_d   = wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == LAST_ADDR) begin
               state_d = ST_WRITE;
            end
         end
`endif
         ST_WRITE: begin
            if (in_valid && in_ready_q) begin
               ram_we_c   = 1'b1;
               wr_addr_d  = wr_addr_q + ADDR_W'(1);
               wr_count_d = wr_count_q + CNT_W'(1);
               if (wr_addr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reset wins over any write attempted in the same cycle.
      if (rst) begin
         ram_we_c = 1'b0;
      end
   end

   // Status flags are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_addr_q  <= '0;
         wr_count_q <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         wr_count_q <= wr_count_d;
         in_ready_q <= (state_d == ST_WRITE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   mem_writer_ram #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .rst_i     (rst),
      .we_i      (ram_we_c),
      .wr_addr_i (wr_addr_q),
      .wr_data_i (ram_wdata_c),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   assign in_ready = in_ready_q;
   assign done     = done_q;
   assign wr_count = wr_count_q;

endmodule : mem_writer

// File: tb/tb_mem_writer.sv
// Directed self-checking bench for mem_writer (default build and MEM_WRITER_CLEAR_EN).
module tb_mem_writer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 256;
`ifdef MEM_WRITER_CLEAR_EN
   localparam int CLR_CYC = 256;
   localparam bit CLR_ON  = 1'b1;
`else
   localparam int CLR_CYC = 0;
   localparam bit CLR_ON  = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic [7:0]       rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [8:0]       wr_count;
   logic             done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_writer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .wr_count (wr_count),
      .done     (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then wait (bounded) for in_ready to rise.
   task automatic do_start(input string tag);
      int waits;
      in_valid = 1'b0;
      start    = 1'b1;
      step();
      start    = 1'b0;
      check_eq({tag, "_cnt0"}, 32'(wr_count), 32'd0);
      check_eq({tag, "_done0"}, 32'(done), 32'd0);
      waits = 0;
      while (in_ready !== 1'b1 && waits < 1000) begin
         step();
         waits++;
      end
      check_eq({tag, "_clear_wait"}, 32'(waits), 32'(CLR_CYC));
      check_eq({tag, "_cnt_after_clear"}, 32'(wr_count), 32'd0);
   endtask

   task automatic readback(input string tag, input int first, input int last, input int ofs);
      for (int i = first; i <= last; i++) begin
         rd_addr = 8'(i);
         step();
         check_eq(tag, 32'(rd_data), 32'((i + ofs) % 16));
      end
   endtask

   initial begin
      int  n;
      int  cyc;
      int  rdy;
      bit  acc;
      bit  st;
      bit  ph;
      bit  chk_new;
      logic [3:0] exp_v;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_done",     32'(done),     32'd0);
      check_eq("rst_wr_count", 32'(wr_count), 32'd0);
      check_eq("rst_rd_data",  32'(rd_data),  32'd0);

      // Pass A: continuous valid, word i = i mod 16, stray start at count 10.
      do_start("passA");
      n = 0; cyc = 0; rdy = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         in_valid = 1'b1;
         in_data  = 4'(n % 16);
         acc      = (in_ready === 1'b1);
         st       = acc && (n == 10);
         start    = st;
         step();
         start    = 1'b0;
         cyc++;
         if (acc) begin
            rdy++;
            n++;
         end
         if (st) check_eq("start_ignored", 32'(wr_count), 32'd11);
      end
      check_eq("passA_ready_cycles", 32'(rdy),      32'd256);
      check_eq("passA_wr_count",     32'(wr_count), 32'd256);
      check_eq("passA_done",         32'(done),     32'd1);
      check_eq("passA_in_ready",     32'(in_ready), 32'd0);
      // valid stays high in DONE with junk data; it must be ignored
      in_data = 4'hF;
      readback("passA_rd", 0, 255, 0);
      check_eq("passA_cnt_hold", 32'(wr_count), 32'd256);
      check_eq("passA_done_hold", 32'(done), 32'd1);

      // Pass B: alternating valid, word i = (i+5) mod 16, read-during-write at 5.
      do_start("passB");
      rd_addr = 8'd5;
      n = 0; cyc = 0; ph = 1'b0; chk_new = 1'b0;
      while (done !== 1'b1 && cyc < 2000) begin
         in_valid = ph;
         in_data  = 4'((n + 5) % 16);
         acc      = ph && (in_ready === 1'b1);
         step();
         cyc++;
         ph = ~ph;
         if (chk_new) begin
            check_eq("rdw_new", 32'(rd_data), 32'hA);
            chk_new = 1'b0;
         end
         if (acc) begin
            if (n == 5) begin
               check_eq("rdw_old", 32'(rd_data), CLR_ON ? 32'd0 : 32'd5);
               chk_new = 1'b1;
            end
            n++;
         end
      end
      in_valid = 1'b0;
      check_eq("passB_words",    32'(n),        32'd256);
      check_eq("passB_cycles",   32'(cyc),      32'd512);
      check_eq("passB_wr_count", 32'(wr_count), 32'd256);
      check_eq("passB_done",     32'(done),     32'd1);
      readback("passB_rd", 0, 255, 5);

      // Pass C: abort with reset at count 100 (reset beats start and valid).
      do_start("passC");
      n = 0; cyc = 0;
      while (n < 100 && cyc < 2000) begin
         in_valid = 1'b1;
         in_data  = 4'((n + 9) % 16);
         acc      = (in_ready === 1'b1);
         step();
         cyc++;
         if (acc) n++;
      end
      check_eq("passC_cnt100", 32'(wr_count), 32'd100);
      rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 4'h3;
      step();
      check_eq("abort_in_ready", 32'(in_ready), 32'd0);
      check_eq("abort_wr_count", 32'(wr_count), 32'd0);
      check_eq("abort_done",     32'(done),     32'd0);
      check_eq("abort_rd_data",  32'(rd_data),  32'd0);
      rst = 1'b0; start = 1'b0;
      step();
      check_eq("idle_in_ready",  32'(in_ready), 32'd0);
      check_eq("idle_wr_count",  32'(wr_count), 32'd0);
      in_valid = 1'b0;
      readback("passC_kept", 0, 99, 9);
      for (int i = 100; i < 104; i++) begin
         rd_addr = 8'(i);
         step();
         exp_v = CLR_ON ? 4'd0 : 4'((i + 5) % 16);
         check_eq("passC_untouched", 32'(rd_data), 32'(exp_v));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mem_writer
